// File: rtl/maze_ram_arbiter.sv
// maze_ram_arbiter
//   Shares the single-port maze cell RAM (40x30 cells, 2 bits each,
//   address = row*40 + col) between three sources, highest priority first:
//     - VGA renderer : read-only, fixed 2-cycle latency, never stalled
//     - clear sweep  : writes CLEAR_VALUE to every cell after i_Clear
//     - generator    : read/write through a valid/ready handshake
//
//   Ports
//     i_Clk, i_Reset                    clock, synchronous active-high reset
//     i_Disp_Req/Addr, o_Disp_Data/Valid renderer read port
//     i_Gen_Valid/Write/Addr/WrData,     generator request
//     o_Gen_Ready                        generator accept (combinational)
//     o_Gen_RdData/RdValid               generator read return
//     o_Gen_Starve                       generator blocked STARVE_LIMIT cycles
//     i_Clear, o_Clear_Busy/Done         clear sweep control and status
//     o_AddrErr                          pulse for a granted address >= CELLS
//     o_Mem_Addr/WrEn/WrData, i_Mem_RdData  registered RAM interface
//     o_DispCount, o_GenCount            grant statistics
//
//   Build option: define MAZE_ARB_STATS_EN to build the saturating grant
//   counters; otherwise o_DispCount/o_GenCount are tied to 0.

module maze_ram_arbiter #(
  parameter int                CELLS        = 1200,
  parameter int                ADDR_W       = 11,
  parameter int                DATA_W       = 2,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = 2'b01,
  parameter int                STARVE_LIMIT = 64
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Disp_Req,
  input  logic [ADDR_W-1:0] i_Disp_Addr,
  output logic [DATA_W-1:0] o_Disp_Data,
  output logic              o_Disp_Valid,
  input  logic              i_Gen_Valid,
  output logic              o_Gen_Ready,
  input  logic              i_Gen_Write,
  input  logic [ADDR_W-1:0] i_Gen_Addr,
  input  logic [DATA_W-1:0] i_Gen_WrData,
  output logic [DATA_W-1:0] o_Gen_RdData,
  output logic              o_Gen_RdValid,
  output logic              o_Gen_Starve,
  input  logic              i_Clear,
  output logic              o_Clear_Busy,
  output logic              o_Clear_Done,
  output logic              o_AddrErr,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic              o_Mem_WrEn,
  output logic [DATA_W-1:0] o_Mem_WrData,
  input  logic [DATA_W-1:0] i_Mem_RdData,
  output logic [15:0]       o_DispCount,
  output logic [15:0]       o_GenCount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int                SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(CELLS);
  endfunction

  function automatic logic [SC_W-1:0] starve_sat_inc(input logic [SC_W-1:0] c);
    return (c == STARVE_MAX) ? c : c + 1'b1;
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [SC_W-1:0]   starve_cnt;

  logic              gen_ready, gen_acc, clr_grant;
  logic              grant_any, grant_we, grant_oor;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  logic [ADDR_W-1:0] mem_addr_p0;
  logic [DATA_W-1:0] mem_wd_p0;
  logic              mem_we_p0, err_p0, rd_err_p0;
  logic              disp_vld_p0, gen_vld_p0;
  logic              disp_vld_p1, gen_vld_p1, rd_err_p1;

  // Grant selection: display always wins, so the clear sweep and the
  // generator only see the cycles the renderer leaves free.
  always_comb begin
    gen_ready  = ~i_Disp_Req & (state == S_IDLE);
    gen_acc    = i_Gen_Valid & gen_ready;
    clr_grant  = ~i_Disp_Req & (state == S_CLEAR);
    grant_addr = i_Disp_Addr;
    grant_data = '0;
    grant_we   = 1'b0;
    if (clr_grant) begin
      grant_addr = clr_cnt;
      grant_data = CLEAR_VALUE;
      grant_we   = 1'b1;
    end else if (gen_acc) begin
      grant_addr = i_Gen_Addr;
      grant_data = i_Gen_WrData;
      grant_we   = i_Gen_Write;
    end
    grant_any = i_Disp_Req | clr_grant | gen_acc;
    grant_oor = grant_any & ~in_range(grant_addr);
  end

  // Stage p0: registered RAM command, one cycle after the grant.
  // Out-of-range writes are dropped here; out-of-range reads keep their
  // strobe and have their data zeroed at the output.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mem_addr_p0 <= '0;
      mem_wd_p0   <= '0;
      mem_we_p0   <= 1'b0;
      err_p0      <= 1'b0;
      rd_err_p0   <= 1'b0;
      disp_vld_p0 <= 1'b0;
      gen_vld_p0  <= 1'b0;
    end else begin
      if (grant_any) begin
        mem_addr_p0 <= grant_addr;
        mem_wd_p0   <= grant_data;
      end
      mem_we_p0   <= grant_we & ~grant_oor;
      err_p0      <= grant_oor;
      rd_err_p0   <= grant_oor & ~grant_we;
      disp_vld_p0 <= i_Disp_Req;
      gen_vld_p0  <= gen_acc & ~i_Gen_Write;
    end
  end

  // Stage p1: RAM read data arrives; steer it to the requester.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      disp_vld_p1 <= 1'b0;
      gen_vld_p1  <= 1'b0;
      rd_err_p1   <= 1'b0;
    end else begin
      disp_vld_p1 <= disp_vld_p0;
      gen_vld_p1  <= gen_vld_p0;
      rd_err_p1   <= rd_err_p0;
    end
  end

  // Clear-sweep sequencer and generator starvation watchdog.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Clear) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_grant) begin
            if (clr_cnt == LAST_CELL) state <= S_DONE;
            else                      clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      starve_cnt <= (i_Gen_Valid & ~gen_ready) ? starve_sat_inc(starve_cnt) : '0;
    end
  end

`ifdef MAZE_ARB_STATS_EN
  function automatic logic [15:0] stat_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] disp_cnt, gen_cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Reset | i_Clear) begin
      disp_cnt <= '0;
      gen_cnt  <= '0;
    end else begin
      if (i_Disp_Req) disp_cnt <= stat_sat_inc(disp_cnt);
      if (gen_acc)    gen_cnt  <= stat_sat_inc(gen_cnt);
    end
  end

  assign o_DispCount = disp_cnt;
  assign o_GenCount  = gen_cnt;
`else
  assign o_DispCount = 16'd0;
  assign o_GenCount  = 16'd0;
`endif

  assign o_Gen_Ready   = gen_ready;
  assign o_Gen_Starve  = (starve_cnt == STARVE_MAX);
  assign o_Clear_Busy  = (state != S_IDLE);
  assign o_Clear_Done  = (state == S_DONE);
  assign o_AddrErr     = err_p0;
  assign o_Mem_Addr    = mem_addr_p0;
  assign o_Mem_WrEn    = mem_we_p0;
  assign o_Mem_WrData  = mem_wd_p0;
  assign o_Disp_Valid  = disp_vld_p1;
  assign o_Disp_Data   = (disp_vld_p1 & ~rd_err_p1) ? i_Mem_RdData : '0;
  assign o_Gen_RdValid = gen_vld_p1;
  assign o_Gen_RdData  = (gen_vld_p1 & ~rd_err_p1) ? i_Mem_RdData : '0;

endmodule

// File: tb/tb_maze_ram_arbiter.sv
module tb_maze_ram_arbiter;
  localparam int CELLS = 1200;
  localparam int LIMIT = 64;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Disp_Req;
  logic [10:0] i_Disp_Addr;
  logic [1:0]  o_Disp_Data;
  logic        o_Disp_Valid;
  logic        i_Gen_Valid;
  logic        o_Gen_Ready;
  logic        i_Gen_Write;
  logic [10:0] i_Gen_Addr;
  logic [1:0]  i_Gen_WrData;
  logic [1:0]  o_Gen_RdData;
  logic        o_Gen_RdValid;
  logic        o_Gen_Starve;
  logic        i_Clear;
  logic        o_Clear_Busy;
  logic        o_Clear_Done;
  logic        o_AddrErr;
  logic [10:0] o_Mem_Addr;
  logic        o_Mem_WrEn;
  logic [1:0]  o_Mem_WrData;
  logic [1:0]  i_Mem_RdData;
  logic [15:0] o_DispCount;
  logic [15:0] o_GenCount;

  always #5 i_Clk = ~i_Clk;

  maze_ram_arbiter dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Disp_Req(i_Disp_Req), .i_Disp_Addr(i_Disp_Addr),
    .o_Disp_Data(o_Disp_Data), .o_Disp_Valid(o_Disp_Valid),
    .i_Gen_Valid(i_Gen_Valid), .o_Gen_Ready(o_Gen_Ready),
    .i_Gen_Write(i_Gen_Write), .i_Gen_Addr(i_Gen_Addr),
    .i_Gen_WrData(i_Gen_WrData), .o_Gen_RdData(o_Gen_RdData),
    .o_Gen_RdValid(o_Gen_RdValid), .o_Gen_Starve(o_Gen_Starve),
    .i_Clear(i_Clear), .o_Clear_Busy(o_Clear_Busy), .o_Clear_Done(o_Clear_Done),
    .o_AddrErr(o_AddrErr), .o_Mem_Addr(o_Mem_Addr), .o_Mem_WrEn(o_Mem_WrEn),
    .o_Mem_WrData(o_Mem_WrData), .i_Mem_RdData(i_Mem_RdData),
    .o_DispCount(o_DispCount), .o_GenCount(o_GenCount)
  );

  function automatic logic [1:0] cell_init(input int i);
    return 2'((i * 7 + (i >> 2) + 1) & 3);
  endfunction

  // Synchronous-read RAM attached to the arbiter; preloaded on the first edge.
  logic [1:0] ram [0:2047];
  bit         ram_inited;
  always @(posedge i_Clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 2048; i++) ram[i] <= cell_init(i);
      ram_inited <= 1'b1;
    end else if (o_Mem_WrEn) begin
      ram[o_Mem_Addr] <= o_Mem_WrData;
    end
    i_Mem_RdData <= ram[o_Mem_Addr];
  end

  // Reference model: expected cell contents plus outputs scheduled by cycle.
  typedef struct {
    bit         disp_vld;
    logic [1:0] disp_data;
    bit         gen_vld;
    logic [1:0] gen_data;
    bit         err;
    bit         we;
    bit         addr_chk;
    logic [10:0] addr;
    logic [1:0] wd;
  } exp_t;

  logic [1:0] shadow [0:CELLS-1];
  exp_t expq [0:3];
  bit   m_busy, m_done, m_acc;
  int   m_next, m_blocked, m_dcnt, m_gcnt, cyc;
  int   checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) expq[i] = '{default: 0};
    m_busy = 0; m_done = 0; m_acc = 0;
    m_next = 0; m_blocked = 0; m_dcnt = 0; m_gcnt = 0;
  endtask

  task automatic sched(input logic [10:0] a, input bit wr, input logic [1:0] d, input bit is_disp);
    int  s1 = (cyc + 1) % 4;
    int  s2 = (cyc + 2) % 4;
    bit  oor = (int'(a) >= CELLS);
    expq[s1].err      = oor;
    expq[s1].addr_chk = 1;
    expq[s1].addr     = a;
    if (wr) begin
      expq[s1].we = !oor;
      expq[s1].wd = d;
      if (!oor) shadow[a] = d;
    end else if (is_disp) begin
      expq[s2].disp_vld  = 1;
      expq[s2].disp_data = oor ? 2'b00 : shadow[a];
    end else begin
      expq[s2].gen_vld  = 1;
      expq[s2].gen_data = oor ? 2'b00 : shadow[a];
    end
  endtask

  // Called at the falling edge: checks this cycle's outputs, then applies
  // this cycle's inputs to the model.
  task automatic model_step();
    int   s = cyc % 4;
    bit   ready = !i_Disp_Req && !m_busy;
    bit   nb = m_busy;
    bit   nd = 0;
    exp_t e = expq[s];
    chk("gen_ready", o_Gen_Ready, ready);
    chk("clear_busy", o_Clear_Busy, m_busy);
    chk("clear_done", o_Clear_Done, m_done);
    chk("gen_starve", o_Gen_Starve, m_blocked >= LIMIT);
    chk("disp_valid", o_Disp_Valid, e.disp_vld);
    chk("disp_data", o_Disp_Data, e.disp_vld ? e.disp_data : 2'b00);
    chk("gen_rdvalid", o_Gen_RdValid, e.gen_vld);
    chk("gen_rddata", o_Gen_RdData, e.gen_vld ? e.gen_data : 2'b00);
    chk("addr_err", o_AddrErr, e.err);
    chk("mem_wren", o_Mem_WrEn, e.we);
    if (e.addr_chk) chk("mem_addr", o_Mem_Addr, e.addr);
    if (e.we) chk("mem_wrdata", o_Mem_WrData, e.wd);
`ifdef MAZE_ARB_STATS_EN
    chk("disp_count", o_DispCount, m_dcnt);
    chk("gen_count", o_GenCount, m_gcnt);
`else
    chk("disp_count", o_DispCount, 0);
    chk("gen_count", o_GenCount, 0);
`endif
    expq[s] = '{default: 0};
    m_acc = 0;
    if (i_Disp_Req) begin
      sched(i_Disp_Addr, 0, 2'b00, 1);
      if (m_dcnt < 65535) m_dcnt++;
    end else if (m_busy && !m_done) begin
      sched(11'(m_next), 1, 2'b01, 0);
      m_next++;
      if (m_next == CELLS) nd = 1;
    end else if (i_Gen_Valid && ready) begin
      sched(i_Gen_Addr, i_Gen_Write, i_Gen_WrData, 0);
      m_acc = 1;
      if (m_gcnt < 65535) m_gcnt++;
    end
    if (i_Gen_Valid && !ready) m_blocked = (m_blocked < LIMIT) ? m_blocked + 1 : LIMIT;
    else m_blocked = 0;
    if (m_done) nb = 0;
    else if (!m_busy && i_Clear) begin nb = 1; m_next = 0; end
    if (i_Clear) begin m_dcnt = 0; m_gcnt = 0; end
    m_busy = nb;
    m_done = nd;
    cyc++;
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge i_Clk); #1;
  endtask

  task automatic tick();
    @(negedge i_Clk);
    finish_cycle();
  endtask

  task automatic idle_inputs();
    i_Disp_Req = 0; i_Disp_Addr = '0; i_Gen_Valid = 0; i_Gen_Write = 0;
    i_Gen_Addr = '0; i_Gen_WrData = '0; i_Clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_Reset = 1;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Reset = 0;
    model_reset();
  endtask

  typedef struct {
    bit dr; logic [10:0] da;
    bit gv; bit gw; logic [10:0] ga; logic [1:0] gd;
    bit exp_ready; bit exp_dv; logic [1:0] exp_dd;
    bit exp_grv; logic [1:0] exp_grd; bit exp_err; bit exp_we;
  } vec_t;

  vec_t tbl [0:11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_rise, wait_cnt, we_cnt, bad, done_cnt;
    bit done_seen;
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < CELLS; i++) shadow[i] = cell_init(i);

    //           dr da    gv gw ga    gd    rdy dv dd     grv grd    err we
    tbl[0]  = '{1, 11'd0,    0, 0, 11'd0,    2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0};
    tbl[1]  = '{1, 11'd39,   0, 0, 11'd0,    2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0};
    tbl[2]  = '{1, 11'd1199, 0, 0, 11'd0,    2'd0, 0, 1, 2'd1, 0, 2'd0, 0, 0};
    tbl[3]  = '{0, 11'd0,    0, 0, 11'd0,    2'd0, 1, 1, 2'd3, 0, 2'd0, 0, 0};
    tbl[4]  = '{0, 11'd0,    0, 0, 11'd0,    2'd0, 1, 1, 2'd1, 0, 2'd0, 0, 0};
    tbl[5]  = '{0, 11'd0,    1, 1, 11'd41,   2'd2, 1, 0, 2'd0, 0, 2'd0, 0, 0};
    tbl[6]  = '{0, 11'd0,    1, 0, 11'd41,   2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 1};
    tbl[7]  = '{0, 11'd0,    0, 0, 11'd0,    2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0};
    tbl[8]  = '{0, 11'd0,    0, 0, 11'd0,    2'd0, 1, 0, 2'd0, 1, 2'd2, 0, 0};
    tbl[9]  = '{0, 11'd0,    1, 1, 11'd1200, 2'd3, 1, 0, 2'd0, 0, 2'd0, 0, 0};
    tbl[10] = '{0, 11'd0,    0, 0, 11'd0,    2'd0, 1, 0, 2'd0, 0, 2'd0, 1, 0};
    tbl[11] = '{0, 11'd0,    0, 0, 11'd0,    2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0};

    do_reset();
    chk("rst_disp_valid", o_Disp_Valid, 0);
    chk("rst_gen_rdvalid", o_Gen_RdValid, 0);
    chk("rst_busy", o_Clear_Busy, 0);
    chk("rst_addr_err", o_AddrErr, 0);
    chk("rst_mem_addr", o_Mem_Addr, 0);
    chk("rst_mem_wren", o_Mem_WrEn, 0);
    chk("rst_gen_ready", o_Gen_Ready, 1);

    // Directed vectors: display burst, generator write/read, bad address.
    for (int r = 0; r < 12; r++) begin
      i_Disp_Req = tbl[r].dr; i_Disp_Addr = tbl[r].da;
      i_Gen_Valid = tbl[r].gv; i_Gen_Write = tbl[r].gw;
      i_Gen_Addr = tbl[r].ga; i_Gen_WrData = tbl[r].gd;
      #1;
      chk("tbl_ready", o_Gen_Ready, tbl[r].exp_ready);
      @(negedge i_Clk);
      chk("tbl_disp_valid", o_Disp_Valid, tbl[r].exp_dv);
      chk("tbl_disp_data", o_Disp_Data, tbl[r].exp_dd);
      chk("tbl_gen_rdvalid", o_Gen_RdValid, tbl[r].exp_grv);
      chk("tbl_gen_rddata", o_Gen_RdData, tbl[r].exp_grd);
      chk("tbl_addr_err", o_AddrErr, tbl[r].exp_err);
      chk("tbl_mem_wren", o_Mem_WrEn, tbl[r].exp_we);
      finish_cycle();
    end
    chk("ram_cell41", ram[41], 2'b10);
    chk("ram_cell1200_untouched", ram[1200], cell_init(1200));

    // Display saturates the port for 70 cycles while the generator waits.
    first_rise = -1;
    i_Gen_Valid = 1; i_Gen_Write = 0; i_Gen_Addr = 11'd5;
    for (int k = 0; k < 70; k++) begin
      i_Disp_Req = 1; i_Disp_Addr = 11'($urandom_range(0, CELLS - 1));
      tick();
      if (o_Gen_Starve && first_rise < 0) first_rise = k + 1;
    end
    chk("starve_rise", first_rise, 64);
    i_Disp_Req = 0;
    tick();
    chk("starve_clear", o_Gen_Starve, 0);
    idle_inputs();
    tick(); tick();

    // Clear sweep, first without and then with display traffic.
    for (int pass = 0; pass < 2; pass++) begin
      i_Clear = 1; tick(); i_Clear = 0;
      wait_cnt = 0; done_seen = 0; we_cnt = 0;
      while (!done_seen && wait_cnt < 3000) begin
        if (o_Mem_WrEn) we_cnt++;
        if (o_Clear_Done) done_seen = 1;
        i_Disp_Req = (pass == 1) && (wait_cnt % 16 == 15);
        i_Disp_Addr = 11'($urandom_range(0, CELLS - 1));
        tick();
        wait_cnt++;
      end
      i_Disp_Req = 0;
      chk("sweep_done_seen", done_seen, 1);
      chk("sweep_write_count", we_cnt, CELLS);
      if (pass == 0) chk("sweep_length", wait_cnt, CELLS + 1);
      chk("sweep_busy_after", o_Clear_Busy, 0);
      chk("sweep_done_after", o_Clear_Done, 0);
      bad = 0;
      for (int i = 0; i < CELLS; i++) if (ram[i] != 2'b01) bad++;
      chk("sweep_ram_cells", bad, 0);
      tick();
    end

    // Reset in the middle of a sweep abandons it without a done pulse.
    i_Clear = 1; tick(); i_Clear = 0;
    repeat (50) tick();
    do_reset();
    done_cnt = 0;
    for (int k = 0; k < 1300; k++) begin
      if (o_Clear_Done || o_Clear_Busy) done_cnt++;
      tick();
    end
    chk("abandoned_sweep", done_cnt, 0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 4000; k++) begin
      if (!i_Gen_Valid || m_acc) begin
        i_Gen_Valid = ($urandom_range(0, 2) != 0);
        i_Gen_Write = 1'($urandom_range(0, 1));
        i_Gen_Addr = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(CELLS, 2047))
                                                  : 11'($urandom_range(0, CELLS - 1));
        i_Gen_WrData = 2'($urandom_range(0, 3));
      end
      i_Disp_Req = ($urandom_range(0, 99) < 35);
      i_Disp_Addr = ($urandom_range(0, 31) == 0) ? 11'($urandom_range(CELLS, 2047))
                                                 : 11'($urandom_range(0, CELLS - 1));
      i_Clear = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_ram_arbiter.md
Name: maze_ram_arbiter

Overview:
- Arbitrates one single-port maze cell RAM between two requesters:
  - the VGA renderer: read-only, fixed latency, strict priority;
  - the maze generator/solver: read/write, valid/ready handshake.
- The RAM holds 1200 cells (40x30 grid, 2 bits/cell), addressed as row*40+col.
- Also sequences a full-maze clear sweep on command.
- Sits between the maze logic, the VGA pixel pipeline and the cell RAM inside top.

Parameters:
- CELLS, 1200, number of valid cell addresses (0..CELLS-1)
- ADDR_W, 11, cell address width
- DATA_W, 2, cell data width
- CLEAR_VALUE, 2'b01, value written to every cell during a clear sweep
- STARVE_LIMIT, 64, consecutive blocked cycles before o_Gen_Starve asserts

Ports:
- i_Clk  in  1  system clock; single clock domain
- i_Reset  in  1  synchronous, active-high reset
- i_Disp_Req  in  1  renderer read request, one per cycle max
- i_Disp_Addr  in  ADDR_W  renderer cell address
- o_Disp_Data  out  DATA_W  renderer read data
- o_Disp_Valid  out  1  renderer data valid
- i_Gen_Valid  in  1  generator request valid
- o_Gen_Ready  out  1  generator request accepted this cycle when high with valid
- i_Gen_Write  in  1  1=write, 0=read
- i_Gen_Addr  in  ADDR_W  generator cell address
- i_Gen_WrData  in  DATA_W  generator write data
- o_Gen_RdData  out  DATA_W  generator read data
- o_Gen_RdValid  out  1  generator read data valid
- o_Gen_Starve  out  1  generator blocked for at least STARVE_LIMIT cycles
- i_Clear  in  1  start clear sweep (pulse)
- o_Clear_Busy  out  1  sweep in progress
- o_Clear_Done  out  1  one-cycle pulse when the sweep completes
- o_AddrErr  out  1  one-cycle pulse for an out-of-range granted access
- o_Mem_Addr  out  ADDR_W  RAM address (registered)
- o_Mem_WrEn  out  1  RAM write enable (registered)
- o_Mem_WrData  out  DATA_W  RAM write data (registered)
- i_Mem_RdData  in  DATA_W  RAM read data, valid 1 cycle after o_Mem_Addr
- o_DispCount  out  16  display grants (stats, see Optional Feature)
- o_GenCount  out  16  generator grants (stats, see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM to S_IDLE, sweep counter 0, starve counter 0. Reset mid-sweep abandons the sweep; no o_Clear_Done.
- Priority per cycle: display > clear sweep > generator.
- o_Gen_Ready is combinational: equals (~i_Disp_Req & state==S_IDLE).
- Memory interface: the grant in cycle N registers o_Mem_* at edge N+1; RAM data returns in cycle N+2.
- Display read: request in cycle N gives o_Disp_Valid=1 with o_Disp_Data in cycle N+2, unconditionally. Back-to-back requests are fully pipelined.
- Generator access accepted in cycle N (valid & ready):
  - Write: o_Mem_WrEn=1 in N+1.
  - Read: o_Gen_RdValid=1 with data in N+2.
- Out-of-range address (>= CELLS) on any granted access:
  - o_AddrErr pulses in N+1.
  - Writes are suppressed (o_Mem_WrEn=0).
  - Reads still return a valid strobe, with data forced to 0.
- FSM states:
  - S_IDLE: i_Clear -> S_CLEAR, counter 0.
  - S_CLEAR: each cycle without i_Disp_Req, write CLEAR_VALUE to the counter address, then counter+1. After writing address CELLS-1 -> S_DONE. i_Clear while busy is ignored.
  - S_DONE: o_Clear_Done=1 for one cycle -> S_IDLE.
- o_Clear_Busy is high in S_CLEAR and S_DONE.
- Simultaneous i_Clear and i_Gen_Valid in S_IDLE (no display request): the generator is granted that cycle and the sweep starts next cycle.
- Starve counter:
  - Increments each cycle i_Gen_Valid & ~o_Gen_Ready, saturating at STARVE_LIMIT.
  - o_Gen_Starve = (counter == STARVE_LIMIT).
  - Cleared on acceptance or when i_Gen_Valid drops.
- Generator must hold its request stable while valid & ~ready.

Optional Feature:
- Macro: MAZE_ARB_STATS_EN.
- Defined:
  - o_DispCount increments on each display grant.
  - o_GenCount increments on each generator acceptance.
  - Both are 16-bit, saturate at 16'hFFFF, cleared by reset and by i_Clear.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Test Plan:
- Reset, idle: all outputs 0, o_Gen_Ready=1 with i_Gen_Valid=0.
- Display reads at addr 0, 39, 1199 on consecutive cycles, with the RAM model preloaded: o_Disp_Valid in cycles N+2..N+4 with matching data, no gaps.
- Generator write 2'b10 to addr 41, then read addr 41 while display is idle: o_Mem_WrEn=1 one cycle after acceptance; o_Gen_RdData=2'b10 two cycles after the read is accepted.
- Display held continuously for 70 cycles with generator valid: ready stays 0, o_Gen_Starve rises exactly 64 cycles after valid, and clears the cycle after acceptance.
- i_Clear with no display traffic: 1200 consecutive writes of 2'b01 to addresses 0..1199, then o_Clear_Done one cycle, o_Clear_Busy low after. With display requests on every 16th cycle, the sweep stretches accordingly and display latency stays 2.
- Generator write to addr 1200: o_AddrErr pulses, no RAM write. With MAZE_ARB_STATS_EN, o_GenCount=1 after the access.
